// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard scoreboard.
// Entry widths are sized for the largest supported register file and depth.
package hazard_pkg;

   localparam int XLEN_DEF        = 32;
   localparam int NUM_REGS_DEF    = 32;
   localparam int DEPTH_DEF       = 3;
   localparam int ALU_READY_DEF   = 0;
   localparam int LOAD_READY_DEF  = 1;
   localparam int FLUSH_DEPTH_DEF = 1;

   localparam int RID_MAX_W = 8;
   localparam int STG_MAX_W = 8;

   typedef struct packed {
      logic                 valid;
      logic [RID_MAX_W-1:0] rd;
      logic [STG_MAX_W-1:0] rdy;
   } entry_t;

   function automatic int rid_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sel_w(input int d);
      return $clog2(d + 1);
   endfunction

endpackage

// File: rtl/operand_resolver.sv
// Youngest-producer match for one ID source operand.
// Picks the lowest matching stage and decides forward versus stall.
module operand_resolver
   import hazard_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int RID_W = 5,
   parameter int SEL_W = 2
) (
   input  entry_t [DEPTH-1:0] ent_i,
   input  logic [RID_W-1:0]   src_i,
   input  logic               used_i,
   input  logic [XLEN-1:0]    stage_data_i [0:DEPTH-1],
   output logic [SEL_W-1:0]   sel_o,
   output logic [XLEN-1:0]    data_o,
   output logic               hazard_o
);

   logic [DEPTH-1:0]     hit;
   logic                 found;
   logic [SEL_W-1:0]     win;
   logic [STG_MAX_W-1:0] win_rdy;

   always_comb begin
      hit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         hit[k] = used_i
                & (src_i != '0)
                & ent_i[k].valid
                & (ent_i[k].rd == RID_MAX_W'(src_i));
      end
   end

   // Scan old to young so the youngest hit is the last one written.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_rdy = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found   = 1'b1;
            win     = SEL_W'(k);
            win_rdy = ent_i[k].rdy;
         end
      end
   end

   always_comb begin
      hazard_o = found & (STG_MAX_W'(win) < win_rdy);
      sel_o    = '0;
      if (found & ~hazard_o) begin
         sel_o = win + SEL_W'(1);
      end
   end

   always_comb begin
      data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel_o == SEL_W'(k + 1)) begin
            data_o = stage_data_i[k];
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: forwarding select, load-use stall and
// a saturating stall counter for the ID stage.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int ALU_READY   = ALU_READY_DEF,
   parameter int LOAD_READY  = LOAD_READY_DEF,
   parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
   localparam int RID_W      = rid_w(NUM_REGS),
   localparam int SEL_W      = sel_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_wb,
   input  logic             issue_is_load,
   input  logic [RID_W-1:0] issue_rd,
   input  logic [RID_W-1:0] src_id [0:1],
   input  logic             src_used [0:1],
   input  logic [XLEN-1:0]  stage_data [0:DEPTH-1],
   input  logic             flush,
   output logic             stall,
   output logic [SEL_W-1:0] fwd_sel [0:1],
   output logic [XLEN-1:0]  fwd_data [0:1],
   output logic [31:0]      stall_cycles
);

   entry_t [DEPTH-1:0] ent_q;
   entry_t [DEPTH-1:0] ent_d;
   logic [31:0]        cnt_q;
   logic [31:0]        cnt_d;
   logic [1:0]         haz;
   logic               ins;
   entry_t             new_e;

   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      operand_resolver #(
         .XLEN  (XLEN),
         .DEPTH (DEPTH),
         .RID_W (RID_W),
         .SEL_W (SEL_W)
      ) u_res (
         .ent_i        (ent_q),
         .src_i        (src_id[gi]),
         .used_i       (src_used[gi]),
         .stage_data_i (stage_data),
         .sel_o        (fwd_sel[gi]),
         .data_o       (fwd_data[gi]),
         .hazard_o     (haz[gi])
      );
   end

   assign stall = issue_valid & ~flush & (|haz);

   assign ins = issue_valid & issue_wb
              & (issue_rd != '0)
              & ~stall & ~flush;

   always_comb begin
      new_e       = '0;
      new_e.valid = ins;
      new_e.rd    = RID_MAX_W'(issue_rd);
      new_e.rdy   = issue_is_load ? STG_MAX_W'(LOAD_READY)
                                  : STG_MAX_W'(ALU_READY);
   end

   // Flushed young stages are killed before they shift onward.
   always_comb begin
      ent_d    = '0;
      ent_d[0] = new_e;
      for (int k = 1; k < DEPTH; k++) begin
         ent_d[k] = ent_q[k-1];
         if (flush && ((k - 1) < FLUSH_DEPTH)) begin
            ent_d[k].valid = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an age-list reference model.
// Literal checks pin the model; a negedge process compares every cycle.
module tb_hazard_scoreboard;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int D    = 3;
   localparam int RW   = 5;
   localparam int SW   = 2;
   localparam int AR   = 0;
   localparam int LR   = 1;
   localparam int FD   = 1;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            issue_valid;
   logic            issue_wb;
   logic            issue_is_load;
   logic [RW-1:0]   issue_rd;
   logic [RW-1:0]   src_id [0:1];
   logic            src_used [0:1];
   logic [XLEN-1:0] stage_data [0:D-1];
   logic            flush;
   logic            stall;
   logic [SW-1:0]   fwd_sel [0:1];
   logic [XLEN-1:0] fwd_data [0:1];
   logic [31:0]     stall_cycles;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .XLEN        (XLEN),
      .NUM_REGS    (NR),
      .DEPTH       (D),
      .ALU_READY   (AR),
      .LOAD_READY  (LR),
      .FLUSH_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_wb      (issue_wb),
      .issue_is_load (issue_is_load),
      .issue_rd      (issue_rd),
      .src_id        (src_id),
      .src_used      (src_used),
      .stage_data    (stage_data),
      .flush         (flush),
      .stall         (stall),
      .fwd_sel       (fwd_sel),
      .fwd_data      (fwd_data),
      .stall_cycles  (stall_cycles)
   );

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Model: list of in-flight writers tagged with age in stages.
   typedef struct {
      int rd;
      bit ld;
      int age;
   } rec_t;

   rec_t   q[$];
   rec_t   nq[$];
   longint m_cnt = 0;

   function automatic void lookup(input int src, input bit used,
                                  output bit haz, output int sel);
      int best;
      best = -1;
      haz  = 0;
      sel  = 0;
      if (!used || src == 0) return;
      foreach (q[j]) begin
         if (q[j].rd == src && (best < 0 || q[j].age < q[best].age))
            best = j;
      end
      if (best < 0) return;
      haz = q[best].age < (q[best].ld ? LR : AR);
      sel = haz ? 0 : q[best].age + 1;
   endfunction

   function automatic bit m_stall();
      bit h0, h1;
      int s;
      lookup(int'(src_id[0]), src_used[0], h0, s);
      lookup(int'(src_id[1]), src_used[1], h1, s);
      return issue_valid && !flush && (h0 || h1);
   endfunction

   always @(posedge clk) begin
      bit st;
      st = m_stall();
      if (!reset) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         nq.delete();
         foreach (q[j]) begin
            if (!(flush && q[j].age < FD) && q[j].age + 1 < D)
               nq.push_back('{q[j].rd, q[j].ld, q[j].age + 1});
         end
         if (issue_valid && issue_wb && issue_rd != 0 && !st && !flush)
            nq.push_back('{int'(issue_rd), issue_is_load, 0});
         q = nq;
      end
   end

   always @(negedge clk) begin
      bit haz;
      int sel;
      logic [XLEN-1:0] ed;
      if (chk_en) begin
         chk("m_stall", stall, m_stall());
         for (int i = 0; i < 2; i++) begin
            lookup(int'(src_id[i]), src_used[i], haz, sel);
            if (!haz) begin
               ed = '0;
               if (sel != 0) ed = stage_data[sel-1];
               chk("m_fwd_sel", fwd_sel[i], sel);
               chk("m_fwd_data", fwd_data[i], ed);
            end
         end
         chk("m_stall_cycles", stall_cycles, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle();
      issue_valid = 0;
      issue_wb = 0;
      issue_is_load = 0;
      issue_rd = '0;
      flush = 0;
      src_used[0] = 0;
      src_used[1] = 0;
      src_id[0] = '0;
      src_id[1] = '0;
   endtask

   task automatic iss(input bit ld, input int rd);
      issue_valid = 1;
      issue_wb = 1;
      issue_is_load = ld;
      issue_rd = RW'(rd);
   endtask

   task automatic use_src(input int i, input int r);
      issue_valid = 1;
      src_used[i] = 1;
      src_id[i] = RW'(r);
   endtask

   initial begin
      idle();
      stage_data[0] = 32'h1111_1111;
      stage_data[1] = 32'h2222_2222;
      stage_data[2] = 32'h3333_3333;
      reset = 0;
      repeat (3) tick();
      reset = 1;
      chk_en = 1;

      use_src(0, 5);
      use_src(1, 9);
      settle();
      chk("rst_stall", stall, 0);
      chk("rst_sel0", fwd_sel[0], 0);
      chk("rst_data0", fwd_data[0], 0);
      chk("rst_cnt", stall_cycles, 0);
      tick(); idle();

      iss(0, 5);
      tick(); idle();
      use_src(0, 5);
      settle();
      chk("alu_stall", stall, 0);
      chk("alu_sel0", fwd_sel[0], 1);
      chk("alu_data0", fwd_data[0], 32'h1111_1111);
      tick(); idle();

      iss(1, 6);
      tick(); idle();
      use_src(1, 6);
      settle();
      chk("ld_stall", stall, 1);
      chk("ld_cnt0", stall_cycles, 0);
      tick();
      settle();
      chk("ld_release", stall, 0);
      chk("ld_sel1", fwd_sel[1], 2);
      chk("ld_data1", fwd_data[1], 32'h2222_2222);
      chk("ld_cnt1", stall_cycles, 1);
      tick(); idle();

      iss(0, 7); tick();
      iss(0, 9); tick();
      iss(0, 7); tick();
      idle();
      use_src(0, 7);
      use_src(1, 9);
      settle();
      chk("yng_stall", stall, 0);
      chk("yng_sel0", fwd_sel[0], 1);
      chk("yng_data0", fwd_data[0], 32'h1111_1111);
      chk("yng_sel1", fwd_sel[1], 2);
      tick(); idle();

      iss(1, 7);
      tick(); idle();
      use_src(0, 7);
      settle();
      chk("yld_stall", stall, 1);
      tick();
      settle();
      chk("yld_release", stall, 0);
      chk("yld_sel0", fwd_sel[0], 2);
      tick(); idle();

      iss(0, 0);
      tick(); idle();
      use_src(0, 0);
      settle();
      chk("x0_stall", stall, 0);
      chk("x0_sel0", fwd_sel[0], 0);
      chk("x0_data0", fwd_data[0], 0);
      tick(); idle();

      iss(1, 12);
      tick(); idle();
      issue_valid = 1;
      src_id[0] = RW'(12);
      settle();
      chk("unused_stall", stall, 0);
      chk("unused_sel0", fwd_sel[0], 0);
      tick(); idle();

      iss(1, 8);
      tick(); idle();
      use_src(0, 8);
      flush = 1;
      settle();
      chk("fl_stall", stall, 0);
      tick();
      flush = 0;
      settle();
      chk("fl_after_stall", stall, 0);
      chk("fl_after_sel0", fwd_sel[0], 0);
      tick(); idle();

      stage_data[0] = 32'hAAAA_0001;
      stage_data[1] = 32'hBBBB_0002;
      stage_data[2] = 32'hCCCC_0003;
      iss(0, 13);
      tick(); iss(0, 14);
      tick(); idle();
      use_src(0, 13);
      use_src(1, 14);
      settle();
      chk("sd_data0", fwd_data[0], 32'hBBBB_0002);
      chk("sd_data1", fwd_data[1], 32'hAAAA_0001);
      tick(); idle();

      reset = 0;
      tick();
      reset = 1;
      for (int n = 0; n < 5; n++) begin
         iss(1, 20 + n);
         tick(); idle();
         use_src(0, 20 + n);
         settle();
         chk("chain_stall", stall, 1);
         tick(); idle();
      end
      settle();
      chk("chain_cnt", stall_cycles, 5);

      iss(0, 1); tick();
      iss(0, 2); tick();
      iss(1, 3); tick();
      idle();
      use_src(0, 3);
      settle();
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_cnt", stall_cycles, 5);
      reset = 0;
      tick();
      reset = 1;
      settle();
      chk("post_rst_stall", stall, 0);
      chk("post_rst_sel0", fwd_sel[0], 0);
      chk("post_rst_cnt", stall_cycles, 0);
      tick(); idle();
      repeat (3) tick();
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
